// File: rtl/bundle_counter_array_if.sv
// Item/result handshake bundle for bundle_counter_array. The master side supplies
// items, tie bits and clear and consumes the result; the slave side is the block.
interface bundle_counter_array_if #(
    parameter int D = 32,
    parameter int W = 16
);
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_vec;
    logic         in_last;
    logic [D-1:0] tie_vec;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] out_vec;
    logic [W-1:0] out_count;
    logic         out_ovf;

    modport master (
        output clear, in_valid, in_vec, in_last, tie_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_count, out_ovf
    );

    modport slave (
        input  clear, in_valid, in_vec, in_last, tie_vec, out_ready,
        output in_ready, out_valid, out_vec, out_count, out_ovf
    );
endinterface

// File: rtl/bundle_counter_array.sv
// Per-lane signed up/down counters that bundle binary hypervectors and emit the majority vector.
// Optional macro BUNDLE_SAT_EN: counters clamp instead of wrapping.
module bundle_counter_array #(
    parameter int D = 32,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bundle_counter_array_if.slave bus,
    output logic                 o_dbg_state,
    output logic [D*W-1:0]       o_dbg_cnt
);

    // Handshakes: an item moves when in_valid && in_ready; a result moves when
    // out_valid && out_ready. Only one of in_ready/out_valid is ever high.
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [W-1:0] CNT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] CNT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_next_state;
    logic [W-1:0] r_cnt [D];
    logic [W-1:0] w_cnt_nxt [D];
    logic [D-1:0] w_lane_ovf;
    logic [W-1:0] r_count;
    logic         r_ovf;
    logic         w_accept;
    logic         w_out_hs;

    assign w_accept = (r_state == ACCUM) && bus.in_valid;
    assign w_out_hs = (r_state == DONE) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.clear) begin
            w_next_state = ACCUM;
        end else begin
            case (r_state)
                ACCUM: if (w_accept && bus.in_last) w_next_state = DONE;
                DONE:  if (w_out_hs) w_next_state = ACCUM;
                default: w_next_state = ACCUM;
            endcase
        end
    end

    // A 0 bit votes +1, a 1 bit votes -1; the sign bit is then the majority bit.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_lane_ovf = '0;
        for (int i = 0; i < D; i++) begin
            if (!bus.in_vec[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_lane_ovf[i] = 1'b1;
`ifdef BUNDLE_SAT_EN
                    w_cnt_nxt[i] = r_cnt[i];
`else
                    w_cnt_nxt[i] = CNT_MIN;
`endif
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end else begin
                if (r_cnt[i] == CNT_MIN) begin
                    w_lane_ovf[i] = 1'b1;
`ifdef BUNDLE_SAT_EN
                    w_cnt_nxt[i] = r_cnt[i];
`else
                    w_cnt_nxt[i] = CNT_MAX;
`endif
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
                end
            end
        end
    end

    // Clear and result handshake both empty the bundle; clear wins over everything but reset.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear || w_out_hs) begin
            for (int i = 0; i < D; i++) r_cnt[i] <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            for (int i = 0; i < D; i++) r_cnt[i] <= w_cnt_nxt[i];
            if (r_count != {W{1'b1}}) r_count <= r_count + CNT_ONE;
            r_ovf <= r_ovf | (|w_lane_ovf);
        end
    end

    always_comb begin
        bus.out_vec = '0;
        o_dbg_cnt   = '0;
        for (int i = 0; i < D; i++) begin
            bus.out_vec[i]      = (r_cnt[i] != '0) ? r_cnt[i][W-1] : bus.tie_vec[i];
            o_dbg_cnt[i*W +: W] = r_cnt[i];
        end
    end

    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_count = r_count;
    assign bus.out_ovf   = r_ovf;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_bundle_counter_array.sv
// Directed bench for bundle_counter_array: a D=4/W=8 instance for the main flows
// and a D=4/W=4 instance for counter overflow and item-count saturation.
module tb_bundle_counter_array;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    bundle_counter_array_if #(.D(4), .W(8)) bus_a ();
    bundle_counter_array_if #(.D(4), .W(4)) bus_b ();

    logic        dbg_state_a;
    logic [31:0] dbg_cnt_a;
    logic        dbg_state_b;
    logic [15:0] dbg_cnt_b;

    bundle_counter_array #(.D(4), .W(8)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_a),
        .o_dbg_state (dbg_state_a),
        .o_dbg_cnt   (dbg_cnt_a)
    );

    bundle_counter_array #(.D(4), .W(4)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_b),
        .o_dbg_state (dbg_state_b),
        .o_dbg_cnt   (dbg_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [3:0] vec, input logic last);
        bus_a.in_valid = 1'b1;
        bus_a.in_vec   = vec;
        bus_a.in_last  = last;
        tick();
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [3:0] vec, input logic last);
        bus_b.in_valid = 1'b1;
        bus_b.in_vec   = vec;
        bus_b.in_last  = last;
        tick();
        bus_b.in_valid = 1'b0;
        bus_b.in_last  = 1'b0;
    endtask

    task automatic drain_a();
        bus_a.out_ready = 1'b1;
        tick();
        bus_a.out_ready = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_a.clear = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_vec = '0;
        bus_a.in_last = 1'b0; bus_a.tie_vec = '0; bus_a.out_ready = 1'b0;
        bus_b.clear = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_vec = '0;
        bus_b.in_last = 1'b0; bus_b.tie_vec = '0; bus_b.out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready",  32'(bus_a.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_count", 32'(bus_a.out_count), 32'd0);
        check("rst_out_ovf",   32'(bus_a.out_ovf), 32'd0);
        check("rst_cnt",       dbg_cnt_a, 32'd0);
        check("rst_b_count",   32'(bus_b.out_count), 32'd0);

        // Three-item bundle: lanes 3..0 end at +1,-1,+1,-1
        send_a(4'b0000, 1'b0);
        check("acc_no_valid", 32'(bus_a.out_valid), 32'd0);
        send_a(4'b1111, 1'b0);
        send_a(4'b0101, 1'b1);
        check("maj_out_valid", 32'(bus_a.out_valid), 32'd1);
        check("maj_in_ready",  32'(bus_a.in_ready), 32'd0);
        check("maj_cnt",       dbg_cnt_a, 32'h01FF01FF);
        check("maj_out_vec",   32'(bus_a.out_vec), 32'h5);
        check("maj_out_count", 32'(bus_a.out_count), 32'd3);
        check("maj_out_ovf",   32'(bus_a.out_ovf), 32'd0);

        // Back-pressure in DONE with in_valid held high
        bus_a.in_valid = 1'b1; bus_a.in_vec = 4'b0000; bus_a.in_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_out_valid", 32'(bus_a.out_valid), 32'd1);
            check("hold_in_ready",  32'(bus_a.in_ready), 32'd0);
            check("hold_out_count", 32'(bus_a.out_count), 32'd3);
            check("hold_out_vec",   32'(bus_a.out_vec), 32'h5);
        end
        bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        drain_a();
        check("drain_in_ready",  32'(bus_a.in_ready), 32'd1);
        check("drain_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("drain_cnt",       dbg_cnt_a, 32'd0);
        check("drain_count",     32'(bus_a.out_count), 32'd0);

        // Tie-break on zero counters, and tie_vec seen combinationally
        bus_a.tie_vec = 4'b1010;
        send_a(4'b0011, 1'b0);
        send_a(4'b1100, 1'b1);
        check("tie_cnt",       dbg_cnt_a, 32'd0);
        check("tie_out_vec",   32'(bus_a.out_vec), 32'hA);
        check("tie_out_count", 32'(bus_a.out_count), 32'd2);
        bus_a.tie_vec = 4'b0110;
        #1;
        check("tie_follow",    32'(bus_a.out_vec), 32'h6);
        drain_a();
        bus_a.tie_vec = 4'b0000;

        // Clear drops the presented last item and the partial bundle
        send_a(4'b0000, 1'b0);
        send_a(4'b0000, 1'b0);
        bus_a.clear = 1'b1; bus_a.in_valid = 1'b1; bus_a.in_vec = 4'b0000; bus_a.in_last = 1'b1;
        tick();
        bus_a.clear = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        check("clr_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("clr_count",     32'(bus_a.out_count), 32'd0);
        check("clr_cnt",       dbg_cnt_a, 32'd0);
        tick();
        check("clr_still_idle", 32'(bus_a.out_valid), 32'd0);
        send_a(4'b1111, 1'b1);
        check("single_out_valid", 32'(bus_a.out_valid), 32'd1);
        check("single_out_vec",   32'(bus_a.out_vec), 32'hF);
        check("single_out_count", 32'(bus_a.out_count), 32'd1);

        // Clear while DONE beats a pending result handshake
        bus_a.clear = 1'b1; bus_a.out_ready = 1'b1;
        tick();
        bus_a.clear = 1'b0; bus_a.out_ready = 1'b0;
        check("clr_done_valid", 32'(bus_a.out_valid), 32'd0);
        check("clr_done_ready", 32'(bus_a.in_ready), 32'd1);
        check("clr_done_count", 32'(bus_a.out_count), 32'd0);

        // Reset in DONE discards the result
        send_a(4'b0000, 1'b0);
        send_a(4'b0000, 1'b1);
        check("pre_rst_valid", 32'(bus_a.out_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(bus_a.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus_a.in_ready), 32'd1);
        check("mid_rst_count", 32'(bus_a.out_count), 32'd0);
        check("mid_rst_state", 32'(dbg_state_a), 32'd0);

        // W=4: nine all-zero items push every lane past +7
        for (int k = 0; k < 8; k++) send_b(4'b0000, 1'b0);
        send_b(4'b0000, 1'b1);
        check("ovf_out_valid", 32'(bus_b.out_valid), 32'd1);
        check("ovf_out_count", 32'(bus_b.out_count), 32'd9);
        check("ovf_flag",      32'(bus_b.out_ovf), 32'd1);
`ifdef BUNDLE_SAT_EN
        check("ovf_cnt",       32'(dbg_cnt_b), 32'h7777);
        check("ovf_out_vec",   32'(bus_b.out_vec), 32'h0);
`else
        check("ovf_cnt",       32'(dbg_cnt_b), 32'h9999);
        check("ovf_out_vec",   32'(bus_b.out_vec), 32'hF);
`endif
        bus_b.out_ready = 1'b1;
        tick();
        bus_b.out_ready = 1'b0;
        check("ovf_cleared", 32'(bus_b.out_ovf), 32'd0);

        // W=4: seventeen alternating items saturate the item count at 15
        for (int k = 0; k < 16; k++) send_b((k % 2 == 0) ? 4'b0000 : 4'b1111, 1'b0);
        send_b(4'b0000, 1'b1);
        check("cntsat_count", 32'(bus_b.out_count), 32'd15);
        check("cntsat_cnt",   32'(dbg_cnt_b), 32'h1111);
        check("cntsat_ovf",   32'(bus_b.out_ovf), 32'd0);
        check("cntsat_vec",   32'(bus_b.out_vec), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
